// File: rtl/multi_switch_pkg.sv
// rtl/multi_switch_pkg.sv - shared types and lamp evaluation for the multi-switch lamp
package multi_switch_pkg;

   // Lamp drive mode as seen after the mode synchroniser
   typedef enum logic {
      MODE_PARITY = 1'b0,
      MODE_ANY    = 1'b1
   } lamp_mode_e;

   // Widest switch vector lamp_eval accepts; narrower vectors are zero-extended,
   // which changes neither the OR nor the XOR reduction.
   localparam int SW_MAX = 32;

   typedef logic [SW_MAX-1:0] sw_vec_t;

   // Lamp level for a given mode and set of debounced switches
   function automatic logic lamp_eval(input lamp_mode_e mode, input sw_vec_t sw_db);
      logic lamp_val;
      if (mode == MODE_ANY) begin
         lamp_val = |sw_db;
      end else begin
         lamp_val = ^sw_db;
      end
      return lamp_val;
   endfunction

endpackage

// File: rtl/multi_switch_lamp_sw_debounce.sv
// rtl/multi_switch_lamp_sw_debounce.sv - one switch channel: 2-FF synchroniser plus debounce counter
module sw_debounce
   import multi_switch_pkg::*;
#(
   parameter int DB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_raw,
   output logic sw_db
);

   localparam int DC_W = $clog2(DB_CYCLES);
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(DB_CYCLES - 1);

   logic            s1;
   logic            s2;
   logic [DC_W-1:0] dc;

   // Bring the raw pin level into the clock domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= sw_raw;
         s2 <= s1;
      end
   end

   // Accept a new level only after it has differed from sw_db for DB_CYCLES edges in a row;
   // any return to the accepted level restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dc    <= '0;
         sw_db <= 1'b0;
      end else if (s2 != sw_db) begin
         if (dc == DC_LAST) begin
            sw_db <= s2;
            dc    <= '0;
         end else begin
            dc <= dc + DC_W'(1);
         end
      end else begin
         dc <= '0;
      end
   end

endmodule

// File: rtl/multi_switch_lamp.sv
// rtl/multi_switch_lamp.sv - N-way multi-control lamp switch with toggle reporting
module multi_switch_lamp
   import multi_switch_pkg::*;
#(
   parameter int N_SW      = 4,
   parameter int DB_CYCLES = 16,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SW-1:0]  sw,
   input  logic             mode,
   output logic [N_SW-1:0]  sw_db,
   output logic             lamp,
   output logic             toggle_pulse,
   output logic [CNT_W-1:0] toggle_cnt
);

   logic mode_s1;
   logic mode_s;
   logic lamp_nx;

   // One independent debouncer per switch channel
   genvar gi;
   generate
      for (gi = 0; gi < N_SW; gi++) begin : g_ch
         sw_debounce #(
            .DB_CYCLES (DB_CYCLES)
         ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .sw_raw (sw[gi]),
            .sw_db  (sw_db[gi])
         );
      end
   endgenerate

   // Mode is a level control; synchronise it but do not debounce it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_s1 <= 1'b0;
         mode_s  <= 1'b0;
      end else begin
         mode_s1 <= mode;
         mode_s  <= mode_s1;
      end
   end

   // Combinational lamp target from the current mode and accepted switch levels
   always_comb begin
      lamp_nx = lamp_eval(lamp_mode_e'(mode_s), sw_vec_t'(sw_db));
   end

   // Register the lamp; any difference from the previous level is one toggle event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lamp         <= 1'b0;
         toggle_pulse <= 1'b0;
         toggle_cnt   <= '0;
      end else begin
         lamp <= lamp_nx;
         if (lamp_nx != lamp) begin
            toggle_pulse <= 1'b1;
            toggle_cnt   <= toggle_cnt + CNT_W'(1);
         end else begin
            toggle_pulse <= 1'b0;
         end
      end
   end

endmodule

// File: doc/multi_switch_lamp.md
# multi_switch_lamp

Parametrised N-way multi-control lamp switch. It generalises the two-switch XOR lamp to `N_SW` raw switch inputs. Each input is synchronised and debounced per channel, and the lamp is driven in one of two modes: parity (any switch flip toggles the lamp) or any-on (OR). The block also reports lamp toggle events and keeps a running toggle count. It sits between board switch pins and LED outputs in the NPC lab top level.

## Interface
Parameters:
- `N_SW`, 4: number of switch channels, ≥ 1.
- `DB_CYCLES`, 16: consecutive stable cycles required to accept a switch change, ≥ 2.
- `CNT_W`, 8: toggle counter width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sw`  in  N_SW  raw, asynchronous, bouncy switch levels.
- `mode`  in  1  0 = parity (XOR of debounced switches), 1 = any-on (OR); asynchronous, level.
- `sw_db`  out  N_SW  debounced switch levels.
- `lamp`  out  1  registered lamp state.
- `toggle_pulse`  out  1  one-cycle pulse when `lamp` changes.
- `toggle_cnt`  out  CNT_W  number of lamp changes, modulo 2^CNT_W.

## Operation
- Per channel:
  - 2-FF synchroniser (`s1`→`s2`) feeds a debounce counter `dc`, `$clog2(DB_CYCLES)` bits.
  - Each edge with `s2 != sw_db[i]`: if `dc == DB_CYCLES-1`, then `sw_db[i] <= s2` and `dc <= 0`; otherwise `dc <= dc+1`.
  - Each edge with `s2 == sw_db[i]`: `dc <= 0`. Any bounce shorter than `DB_CYCLES` synchronised cycles is rejected.
- `mode` passes through its own 2-FF synchroniser (`mode_s`). It is not debounced.
- Next lamp value: `lamp_nx = mode_s ? |sw_db : ^sw_db`.
- Each edge:
  - `lamp <= lamp_nx`.
  - If `lamp_nx != lamp`: `toggle_pulse <= 1` and `toggle_cnt <= toggle_cnt + 1` (wraps to 0).
  - Otherwise: `toggle_pulse <= 0`.
- Source of the lamp change:
  - Any change counts as a toggle, including a mode change.
  - Several channels accepted on the same edge are evaluated together. An even number of parity flips produces no toggle.
- Reset (`rst_n` low, asynchronous):
  - All synchronisers, `dc`, `sw_db`, `lamp`, `toggle_pulse` and `toggle_cnt` go to 0.
  - In-progress debounces are discarded.
  - After release, inputs already high are re-debounced from scratch. Their acceptance produces normal toggles.

## Timing
- Reset values: every output is 0.
- Switch-to-`sw_db` latency: a change first sampled into `s1` at edge 0 appears on `sw_db` after edge `DB_CYCLES+1`, provided it is held stable throughout.
- `sw_db`-to-`lamp` latency: one edge. `lamp`, `toggle_pulse` and `toggle_cnt` update on the same edge, so total latency is `DB_CYCLES+2` edges.
- Mode-to-`lamp` latency: 3 edges (2 synchroniser edges + 1 register edge).
- `toggle_pulse` width: exactly one cycle per change. Back-to-back toggles on consecutive edges give consecutive pulses.
- Release of `rst_n`: assumed synchronous to `clk` at system level. No internal reset synchroniser.

## Structure
- Package `multi_switch_pkg`:
  - `lamp_mode_e` enum: `MODE_PARITY` = 0, `MODE_ANY` = 1.
  - Function `lamp_eval(mode, sw_db)`.
- Sub-module `sw_debounce`:
  - One channel: synchroniser, counter and accepted level.
  - Parameter `DB_CYCLES`; ports `clk`, `rst_n`, `sw_raw`, `sw_db`.
  - Instantiated `N_SW` times in a generate loop.
- Top level holds the mode synchroniser, lamp register and toggle counter.

## Test plan
All scenarios use `N_SW=4`, `DB_CYCLES=4`, `CNT_W=4`.
- **Reset:** assert `rst_n` low mid-run with `sw=4'b1010` → all outputs 0 immediately. After release, `sw_db=4'b1010` after 5 edges; parity lamp stays 0 (no pulse).
- **Single switch:** `sw` 0000→0001, held → `sw_db=0001` after edge 5; `lamp=1`, `toggle_pulse=1` for one cycle and `toggle_cnt=1` after edge 6.
- **Bounce rejection:** from 0001, raise `sw[1]` for 3 cycles then drop it → `sw_db` stays 0001, no pulse, `toggle_cnt` unchanged. The same bounce interrupted by reset also leaves no residue.
- **Simultaneous channels:** `sw` 0001→0111 on one edge, parity mode → `sw_db=0111` on the same edge for both channels; `lamp` stays 1, no pulse.
- **Mode switch:** `sw_db=0011`, `mode` 0→1 → `lamp` 0→1 after 3 edges, one pulse, `toggle_cnt` +1. Back to 0 → `lamp` returns to 0 with another pulse.
- **Counter wrap:** 16 accepted single-switch flips in parity mode → `toggle_cnt` goes 15→0 and `toggle_pulse` is still issued on the wrap.
